fft_mem_sched: RTL and testbench
================================

// Module: fft_mem_sched
// PURPOSE
//  Controller/arbiter for the 32-word flop-based FFT sample memory. Shares its single write port between
//  CPU sample stores and FFT-accelerator result writeback, and sequences a run: CPU load -> arm -> accelerator
//  compute/writeback -> done. Drives the memory's en_i/we_i/addr_i/data_i/accel_mem_en pins directly.
// PARAMETERS
//  DEPTH      32                   number of valid sample words; addresses >= DEPTH are out of range
//  WORDWIDTH  16                   sample word width
//  ADDRW      $clog2(DEPTH+1)      address width, matches memory addr_i
//  TIMEOUT    1024                 watchdog limit in cycles (used only with FFT_MEM_TIMEOUT_EN)
// PORTS
//  clk             in   1          clock
//  rst             in   1          synchronous reset, active-low
//  cpu_req_i       in   1          CPU sample write request
//  cpu_addr_i      in   ADDRW      CPU write address
//  cpu_data_i      in   WORDWIDTH  CPU write data
//  cpu_gnt_o       out  1          CPU write accepted this cycle (combinational)
//  start_i         in   1          start-run pulse from CSR
//  acc_start_o     out  1          one-cycle pulse: accelerator may begin reading memory
//  acc_wb_valid_i  in   1          accelerator result write valid
//  acc_wb_addr_i   in   ADDRW      result address
//  acc_wb_data_i   in   WORDWIDTH  result data
//  acc_wb_ready_o  out  1          result write accepted (valid&ready = transfer)
//  acc_done_i      in   1          accelerator finished pulse
//  mem_en_o/mem_we_o out 1         memory en_i/we_i (CPU writes)
//  accel_mem_en_o  out  1          memory accel_mem_en (accelerator writes)
//  mem_addr_o      out  ADDRW      memory addr_i
//  mem_data_o      out  WORDWIDTH  memory data_i
//  busy_o          out  1          state is ARM or RUN
//  done_o          out  1          state is DONE
//  err_o           out  1          sticky: count mismatch, out-of-range write, or timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, wb counter 0, err 0. Reset mid-run aborts immediately to IDLE.
//  States: IDLE -start_i-> ARM (1 cycle) -> RUN -acc_done_i-> DONE -start_i-> ARM.
//  cpu_gnt_o = cpu_req_i & (IDLE|DONE); CPU is stalled (gnt 0) in ARM/RUN, request held by requester.
//  acc_wb_ready_o = (state==RUN); CPU and accelerator never granted in the same cycle.
//  Memory pins registered: transfer in cycle N -> mem_* for exactly one cycle at N+1. CPU transfer drives
//   mem_en_o=mem_we_o=1; accelerator transfer drives accel_mem_en_o=1; idle cycles drive all enables 0,
//   addr/data hold last value.
//  Out-of-range address (>= DEPTH): handshake completes, memory enables stay 0, err set.
//  start_i with cpu_req_i in IDLE/DONE: CPU write granted that cycle, then ARM; ARM flushes it to memory.
//  acc_start_o pulses for exactly the first RUN cycle. start_i in ARM/RUN ignored.
//  Entering ARM clears wb counter, err and done.
//  RUN: counter (ADDRW+1 bits, saturating at DEPTH) increments per accelerator transfer. acc_done_i ->
//   DONE; counter != DEPTH at that moment sets err. A transfer in the same cycle as acc_done_i is counted first.
//  acc_done_i / acc_wb_valid_i outside RUN ignored (no write, no err).
// CONFIGURATION
//  FFT_MEM_TIMEOUT_EN defined: watchdog counts RUN cycles without an accelerator transfer, reset by each
//   transfer; reaching TIMEOUT forces DONE with err=1. Undefined: no watchdog, RUN waits for acc_done_i forever.
// TESTING
//  Reset then 32 CPU writes addr 0..31 data 16'h1000+addr -> 32 one-cycle mem_en_o/we_o pulses, addr/data one cycle later.
//  start_i in IDLE -> busy_o=1, acc_start_o exactly 2 cycles later; cpu_req_i during RUN -> cpu_gnt_o=0 until DONE.
//  32 acc writes then acc_done_i -> 32 accel_mem_en_o pulses, done_o=1, err_o=0; 31 writes + done -> err_o=1.
//  CPU write addr 32 (DEPTH=32) -> cpu_gnt_o=1, no mem enable, err_o=1; next start_i clears err_o.
//  start_i and cpu_req_i together in DONE -> write reaches memory in ARM cycle, then acc_start_o; rst=0 in RUN -> IDLE, all outputs 0.
//  FFT_MEM_TIMEOUT_EN, TIMEOUT=16, no acc activity -> DONE with err_o=1 after 16 RUN cycles.

Source files
------------

// File: rtl/fft_mem_sched.sv
// fft_mem_sched: write-port arbiter and run sequencer for the 32-word FFT sample memory.
// CPU sample stores and accelerator result writeback share the memory's single write port.
// The run sequence is IDLE -> ARM -> RUN -> DONE. Memory pins are registered one cycle after each transfer.
// Optional feature: define FFT_MEM_TIMEOUT_EN to enable the RUN watchdog. The limit is set by TIMEOUT.
module fft_mem_sched #(
    parameter int DEPTH     = 32,
    parameter int WORDWIDTH = 16,
    parameter int ADDRW     = $clog2(DEPTH + 1),
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req_i,
    input  logic [ADDRW-1:0]     cpu_addr_i,
    input  logic [WORDWIDTH-1:0] cpu_data_i,
    output logic                 cpu_gnt_o,
    input  logic                 start_i,
    output logic                 acc_start_o,
    input  logic                 acc_wb_valid_i,
    input  logic [ADDRW-1:0]     acc_wb_addr_i,
    input  logic [WORDWIDTH-1:0] acc_wb_data_i,
    output logic                 acc_wb_ready_o,
    input  logic                 acc_done_i,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic                 accel_mem_en_o,
    output logic [ADDRW-1:0]     mem_addr_o,
    output logic [WORDWIDTH-1:0] mem_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [ADDRW-1:0] DEPTH_A = ADDRW'(DEPTH);
    localparam logic [ADDRW:0]   DEPTH_C = (ADDRW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [ADDRW:0]       wb_cnt, wb_cnt_nxt, cnt_now;
    logic                 err, err_nxt;
    logic                 cpu_xfer, acc_xfer;
    logic                 cpu_in_range, acc_in_range;

    logic                 acc_start_p1;
    logic                 mem_en_p1;
    logic                 accel_en_p1;
    logic [ADDRW-1:0]     mem_addr_p1;
    logic [WORDWIDTH-1:0] mem_data_p1;

`ifdef FFT_MEM_TIMEOUT_EN
    localparam int             WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] TIMEOUT_W = WDW'(TIMEOUT);
    logic [WDW-1:0] wd_cnt, wd_cnt_nxt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // The write-back count saturates at DEPTH, so extra transfers cannot wrap back to a "correct" count.
    function automatic logic [ADDRW:0] sat_inc(input logic [ADDRW:0] c);
        return (c >= DEPTH_C) ? DEPTH_C : c + (ADDRW + 1)'(1);
    endfunction

    // Grants depend only on state, so the CPU and the accelerator are never granted in the same cycle.
    assign cpu_gnt_o      = cpu_req_i && (state == S_IDLE || state == S_DONE);
    assign acc_wb_ready_o = (state == S_RUN);
    assign cpu_xfer       = cpu_gnt_o;
    assign acc_xfer       = acc_wb_valid_i && acc_wb_ready_o;
    assign cpu_in_range   = (cpu_addr_i < DEPTH_A);
    assign acc_in_range   = (acc_wb_addr_i < DEPTH_A);

    assign busy_o = (state == S_ARM) || (state == S_RUN);
    assign done_o = (state == S_DONE);
    assign err_o  = err;

    // Next-state logic: run sequencing, write-back counting and sticky error.
    always_comb begin
        state_nxt  = state;
        wb_cnt_nxt = wb_cnt;
        err_nxt    = err;
        cnt_now    = acc_xfer ? sat_inc(wb_cnt) : wb_cnt;
`ifdef FFT_MEM_TIMEOUT_EN
        wd_cnt_nxt = '0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_nxt  = S_ARM;
                    wb_cnt_nxt = '0;
                    err_nxt    = 1'b0;
                end
            end
            S_ARM: state_nxt = S_RUN;
            S_RUN: begin
                wb_cnt_nxt = cnt_now;
                if (acc_xfer && !acc_in_range) err_nxt = 1'b1;
                if (acc_done_i) begin
                    state_nxt = S_DONE;
                    if (cnt_now != DEPTH_C) err_nxt = 1'b1;
                end
`ifdef FFT_MEM_TIMEOUT_EN
                else begin
                    wd_cnt_nxt = acc_xfer ? '0 : wd_cnt + WDW'(1);
                    if (!acc_xfer && wd_cnt_nxt == TIMEOUT_W) begin
                        state_nxt = S_DONE;
                        err_nxt   = 1'b1;
                    end
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
        // An out-of-range CPU store granted alongside start_i is still reported after the ARM clear.
        if (cpu_xfer && !cpu_in_range) err_nxt = 1'b1;
    end

    // Control state register; active-low synchronous reset aborts any run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            wb_cnt <= '0;
            err    <= 1'b0;
`ifdef FFT_MEM_TIMEOUT_EN
            wd_cnt <= '0;
`endif
        end else begin
            state  <= state_nxt;
            wb_cnt <= wb_cnt_nxt;
            err    <= err_nxt;
`ifdef FFT_MEM_TIMEOUT_EN
            wd_cnt <= wd_cnt_nxt;
`endif
        end
    end

    // Stage p1: register the memory pins one cycle after the transfer. Addr and data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_start_p1 <= 1'b0;
            mem_en_p1    <= 1'b0;
            accel_en_p1  <= 1'b0;
            mem_addr_p1  <= '0;
            mem_data_p1  <= '0;
        end else begin
            acc_start_p1 <= (state == S_ARM);
            mem_en_p1    <= cpu_xfer && cpu_in_range;
            accel_en_p1  <= acc_xfer && acc_in_range;
            if (cpu_xfer && cpu_in_range) begin
                mem_addr_p1 <= cpu_addr_i;
                mem_data_p1 <= cpu_data_i;
            end else if (acc_xfer && acc_in_range) begin
                mem_addr_p1 <= acc_wb_addr_i;
                mem_data_p1 <= acc_wb_data_i;
            end
        end
    end

    assign acc_start_o    = acc_start_p1;
    assign mem_en_o       = mem_en_p1;
    assign mem_we_o       = mem_en_p1;
    assign accel_mem_en_o = accel_en_p1;
    assign mem_addr_o     = mem_addr_p1;
    assign mem_data_o     = mem_data_p1;

endmodule

// File: tb/tb_fft_mem_sched.sv
// tb_fft_mem_sched: scoreboard bench for fft_mem_sched.
// Expected memory writes are queued when stimulus is driven, and then checked as the memory pins fire.
module tb_fft_mem_sched;

    localparam int DEPTH     = 32;
    localparam int WORDWIDTH = 16;
    localparam int ADDRW     = $clog2(DEPTH + 1);
    localparam int TIMEOUT   = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cpu_req_i = 1'b0;
    logic [ADDRW-1:0]     cpu_addr_i = '0;
    logic [WORDWIDTH-1:0] cpu_data_i = '0;
    logic                 cpu_gnt_o;
    logic                 start_i = 1'b0;
    logic                 acc_start_o;
    logic                 acc_wb_valid_i = 1'b0;
    logic [ADDRW-1:0]     acc_wb_addr_i = '0;
    logic [WORDWIDTH-1:0] acc_wb_data_i = '0;
    logic                 acc_wb_ready_o;
    logic                 acc_done_i = 1'b0;
    logic                 mem_en_o, mem_we_o, accel_mem_en_o;
    logic [ADDRW-1:0]     mem_addr_o;
    logic [WORDWIDTH-1:0] mem_data_o;
    logic                 busy_o, done_o, err_o;

    typedef struct {
        bit                   acc;
        logic [ADDRW-1:0]     addr;
        logic [WORDWIDTH-1:0] data;
        int                   cyc;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    fft_mem_sched #(
        .DEPTH(DEPTH), .WORDWIDTH(WORDWIDTH), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_gnt_o(cpu_gnt_o),
        .start_i(start_i), .acc_start_o(acc_start_o),
        .acc_wb_valid_i(acc_wb_valid_i), .acc_wb_addr_i(acc_wb_addr_i), .acc_wb_data_i(acc_wb_data_i),
        .acc_wb_ready_o(acc_wb_ready_o), .acc_done_i(acc_done_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .accel_mem_en_o(accel_mem_en_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: each memory pulse must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL mem_write_missing: expected addr=%0d data=%h in cycle %0d, nothing seen by cycle %0d",
                     mon_e.addr, mon_e.data, mon_e.cyc, cyc);
        end
        if (mem_en_o === 1'b1 || accel_mem_en_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL mem_write_unexpected: en=%b we=%b accel=%b addr=%0d data=%h cycle %0d, none expected",
                         mem_en_o, mem_we_o, accel_mem_en_o, mem_addr_o, mem_data_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                if ({mem_en_o, mem_we_o, accel_mem_en_o} !== {!mon_e.acc, !mon_e.acc, mon_e.acc} ||
                    mem_addr_o !== mon_e.addr || mem_data_o !== mon_e.data || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL mem_write: got en/we/accel=%b%b%b addr=%0d data=%h cyc=%0d, expected %b%b%b addr=%0d data=%h cyc=%0d",
                             mem_en_o, mem_we_o, accel_mem_en_o, mem_addr_o, mem_data_o, cyc,
                             !mon_e.acc, !mon_e.acc, mon_e.acc, mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        cpu_req_i = 1'b0; start_i = 1'b0; acc_wb_valid_i = 1'b0; acc_done_i = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        checks++;
        if ({busy_o, done_o, err_o, acc_start_o, acc_wb_ready_o, cpu_gnt_o, mem_en_o, mem_we_o, accel_mem_en_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b, expected 000000000",
                     {busy_o, done_o, err_o, acc_start_o, acc_wb_ready_o, cpu_gnt_o, mem_en_o, mem_we_o, accel_mem_en_o});
        end
        checks++;
        if (mem_addr_o !== '0 || mem_data_o !== '0) begin
            failures++;
            $display("FAIL reset_addr_data: got addr=%0d data=%h, expected 0/0", mem_addr_o, mem_data_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_load;
        for (int a = 0; a < DEPTH; a++) begin
            cpu_req_i  = 1'b1;
            cpu_addr_i = ADDRW'(a);
            cpu_data_i = WORDWIDTH'(16'h1000 + a);
            #1;
            checks++;
            if (cpu_gnt_o !== 1'b1) begin
                failures++;
                $display("FAIL cpu_load_gnt: addr %0d got gnt=%b, expected 1", a, cpu_gnt_o);
            end
            sb.push_back('{acc: 1'b0, addr: ADDRW'(a), data: WORDWIDTH'(16'h1000 + a), cyc: cyc + 1});
            @(negedge clk);
        end
        cpu_req_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL cpu_load_err: got err=%b, expected 0", err_o);
        end
    endtask

    task automatic test_acc_ignored_idle;
        acc_wb_valid_i = 1'b1;
        acc_wb_addr_i  = ADDRW'(4);
        acc_wb_data_i  = 16'hDEAD;
        acc_done_i     = 1'b1;
        #1;
        checks++;
        if (acc_wb_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_acc_ready: got %b, expected 0", acc_wb_ready_o);
        end
        @(negedge clk);
        acc_wb_valid_i = 1'b0;
        acc_done_i     = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, err_o} !== 3'b000) begin
            failures++;
            $display("FAIL idle_acc_ignored: busy/done/err got %b, expected 000", {busy_o, done_o, err_o});
        end
    endtask

    // Full run: start, n accelerator writes, done (separately or together with the last write).
    task automatic test_run(input int n, input bit done_with_last, input bit exp_err);
        start_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL run_pre_busy: got %b, expected 0", busy_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if ({busy_o, acc_start_o, done_o, err_o} !== 4'b1000) begin
            failures++;
            $display("FAIL run_arm: busy/acc_start/done/err got %b, expected 1000", {busy_o, acc_start_o, done_o, err_o});
        end
        @(negedge clk);
        checks++;
        if ({acc_start_o, acc_wb_ready_o, busy_o} !== 3'b111) begin
            failures++;
            $display("FAIL run_first: acc_start/ready/busy got %b, expected 111", {acc_start_o, acc_wb_ready_o, busy_o});
        end
        for (int i = 0; i < n; i++) begin
            acc_wb_valid_i = 1'b1;
            acc_wb_addr_i  = ADDRW'(i);
            acc_wb_data_i  = WORDWIDTH'(16'hA000 + i * 16'h0101);
            cpu_req_i      = 1'b1;
            cpu_addr_i     = ADDRW'(3);
            cpu_data_i     = 16'h3333;
            if (done_with_last && i == n - 1) acc_done_i = 1'b1;
            #1;
            checks++;
            if (cpu_gnt_o !== 1'b0) begin
                failures++;
                $display("FAIL run_cpu_stall: write %0d got gnt=%b, expected 0", i, cpu_gnt_o);
            end
            sb.push_back('{acc: 1'b1, addr: ADDRW'(i), data: WORDWIDTH'(16'hA000 + i * 16'h0101), cyc: cyc + 1});
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (acc_start_o !== 1'b0) begin
                    failures++;
                    $display("FAIL run_start_pulse: second RUN cycle got acc_start=%b, expected 0", acc_start_o);
                end
            end
        end
        acc_wb_valid_i = 1'b0;
        if (!done_with_last) begin
            acc_done_i = 1'b1;
            @(negedge clk);
        end
        acc_done_i = 1'b0;
        checks++;
        if ({done_o, busy_o, err_o, acc_wb_ready_o} !== {1'b1, 1'b0, exp_err, 1'b0}) begin
            failures++;
            $display("FAIL run_done n=%0d: done/busy/err/ready got %b, expected %b",
                     n, {done_o, busy_o, err_o, acc_wb_ready_o}, {1'b1, 1'b0, exp_err, 1'b0});
        end
        #1;
        checks++;
        if (cpu_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL run_done_gnt: got gnt=%b in DONE, expected 1", cpu_gnt_o);
        end
        cpu_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_oor_cpu;
        cpu_req_i  = 1'b1;
        cpu_addr_i = ADDRW'(DEPTH);
        cpu_data_i = 16'hBEEF;
        #1;
        checks++;
        if (cpu_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL oor_gnt: got %b, expected 1", cpu_gnt_o);
        end
        @(negedge clk);
        cpu_req_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL oor_err: got %b, expected 1", err_o);
        end
        @(negedge clk);
    endtask

    task automatic test_start_with_cpu;
        start_i    = 1'b1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = ADDRW'(7);
        cpu_data_i = 16'h7777;
        #1;
        checks++;
        if (cpu_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL start_cpu_gnt: got %b, expected 1", cpu_gnt_o);
        end
        sb.push_back('{acc: 1'b0, addr: ADDRW'(7), data: 16'h7777, cyc: cyc + 1});
        @(negedge clk);
        start_i   = 1'b0;
        cpu_req_i = 1'b0;
        checks++;
        if ({busy_o, acc_start_o} !== 2'b10) begin
            failures++;
            $display("FAIL start_cpu_arm: busy/acc_start got %b, expected 10", {busy_o, acc_start_o});
        end
        @(negedge clk);
        checks++;
        if (acc_start_o !== 1'b1) begin
            failures++;
            $display("FAIL start_cpu_acc_start: got %b, expected 1", acc_start_o);
        end
    endtask

    task automatic test_reset_in_run;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, done_o, err_o, acc_start_o, acc_wb_ready_o, mem_en_o, mem_we_o, accel_mem_en_o} !== 8'b0 ||
            mem_addr_o !== '0 || mem_data_o !== '0) begin
            failures++;
            $display("FAIL reset_in_run: ctrl=%b addr=%0d data=%h, expected all 0",
                     {busy_o, done_o, err_o, acc_start_o, acc_wb_ready_o, mem_en_o, mem_we_o, accel_mem_en_o},
                     mem_addr_o, mem_data_o);
        end
        rst = 1'b1;
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = ADDRW'(1);
        cpu_data_i = 16'h0101;
        #1;
        checks++;
        if (cpu_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_run_idle_gnt: got %b, expected 1", cpu_gnt_o);
        end
        sb.push_back('{acc: 1'b0, addr: ADDRW'(1), data: 16'h0101, cyc: cyc + 1});
        @(negedge clk);
        cpu_req_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef FFT_MEM_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) break;
            n++;
        end
        checks++;
        if (n != TIMEOUT || err_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout: RUN cycles=%0d err=%b, expected %0d and 1", n, err_o, TIMEOUT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_load();
        test_acc_ignored_idle();
        test_run(32, 1'b0, 1'b0);
        test_run(31, 1'b0, 1'b1);
        test_run(32, 1'b1, 1'b0);
        test_oor_cpu();
        test_run(32, 1'b0, 1'b0);
        test_start_with_cpu();
        test_reset_in_run();
`ifdef FFT_MEM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d writes still pending, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
